// File: rtl/ssd_scan_ctrl_if.sv
// ssd_scan_ctrl_if: control/data and pin bundle between game logic and the SSD scanner.
//   enable      scan on (1) / display off (0)
//   load        one-cycle strobe capturing value/dp_in/blank_in
//   value       hex nibbles, digit 0 in value[3:0] (rightmost)
//   dp_in       per-digit decimal point request, 1 = lit
//   blank_in    per-digit blank, 1 = dark
//   lz_suppress 1 = suppress leading zeros (used live)
//   An          anodes, active low
//   Cath        {Ca..Cg}, active low
//   Dp          decimal point, active low
//   frame_done  one-cycle pulse when digit 0's slot begins after a wrap
//   pending     shadow holds data not yet shown
interface ssd_scan_ctrl_if #(
   parameter int NUM_DIGITS = 8
);
   logic                    enable;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic                    lz_suppress;
   logic [NUM_DIGITS-1:0]   An;
   logic [6:0]              Cath;
   logic                    Dp;
   logic                    frame_done;
   logic                    pending;
   modport master (
      output enable, load, value, dp_in, blank_in, lz_suppress,
      input  An, Cath, Dp, frame_done, pending
   );
   modport slave (
      input  enable, load, value, dp_in, blank_in, lz_suppress,
      output An, Cath, Dp, frame_done, pending
   );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: N-digit multiplexed seven-segment scanner with guard interval and frame-synchronous double buffer.
//   ClkPort  system clock
//   Reset_n  asynchronous active-low reset
//   bus      ssd_scan_ctrl_if slave: enable/load/value/dp_in/blank_in/lz_suppress in,
//            An/Cath/Dp/frame_done/pending out
module ssd_scan_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int TICK_DIV   = 100000,
   parameter int GUARD      = 2000
) (
   input logic            ClkPort,
   input logic            Reset_n,
   ssd_scan_ctrl_if.slave bus
);
   localparam int N  = NUM_DIGITS;
   localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int IW = N > 1 ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_OFF, S_GUARD, S_DRIVE} state_t;

   state_t          r_state, w_state_n;
   logic [CW-1:0]   r_cnt, w_cnt_n;
   logic [IW-1:0]   r_idx, w_idx_n;
   logic            w_slot_end, w_wrap, r_wrapped;
   logic [4*N-1:0]  r_sh_val, r_act_val;
   logic [N-1:0]    r_sh_dp, r_sh_bl, r_act_dp, r_act_bl;
   logic            r_pending;
   logic [N-1:0]    w_lz, w_an, r_an;
   logic [3:0]      w_nib;
   logic            w_dark, w_lit, w_dp, r_dp, r_fd;
   logic [6:0]      w_cath, r_cath;

   function automatic logic [6:0] seg7(input logic [3:0] h);
      case (h)
         4'h0: seg7 = 7'b0000001;
         4'h1: seg7 = 7'b1001111;
         4'h2: seg7 = 7'b0010010;
         4'h3: seg7 = 7'b0000110;
         4'h4: seg7 = 7'b1001100;
         4'h5: seg7 = 7'b0100100;
         4'h6: seg7 = 7'b0100000;
         4'h7: seg7 = 7'b0001111;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0000100;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b1100000;
         4'hC: seg7 = 7'b0110001;
         4'hD: seg7 = 7'b1000010;
         4'hE: seg7 = 7'b0110000;
         default: seg7 = 7'b0111000;
      endcase
   endfunction

   always_ff @(posedge ClkPort or negedge Reset_n)
      if (!Reset_n) begin
         r_state   <= S_OFF;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_wrapped <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_cnt     <= w_cnt_n;
         r_idx     <= w_idx_n;
         r_wrapped <= w_wrap;
      end

   // The OFF cycle in which enable is seen counts as cnt 0 of digit 0's slot,
   // so the first anode goes low GUARD+1 edges after enable rises.
   always_comb begin
      w_slot_end = r_cnt == CW'(TICK_DIV - 1);
      w_wrap     = (r_state != S_OFF) && w_slot_end && (r_idx == IW'(N - 1));
      w_cnt_n    = (!bus.enable || w_slot_end) ? '0 : r_cnt + 1'b1;
      w_idx_n    = (!bus.enable || w_wrap) ? '0 :
                   (w_slot_end && r_state != S_OFF) ? r_idx + 1'b1 : r_idx;
      w_state_n  = !bus.enable ? S_OFF : (int'(w_cnt_n) < GUARD) ? S_GUARD : S_DRIVE;
   end

   // Cath follows the current digit during its guard so segments only change with anodes off.
   always_comb begin
      logic z;
      z    = 1'b1;
      w_lz = '0;
      for (int i = N - 1; i >= 0; i--) begin
         z       = z & (r_act_val[4*i +: 4] == 4'h0);
         w_lz[i] = z;
      end
      w_nib  = r_act_val[4*r_idx +: 4];
      w_dark = r_act_bl[r_idx] | (bus.lz_suppress & (r_idx != '0) & w_lz[r_idx]);
      w_lit  = (r_state == S_DRIVE) & ~w_dark;
      w_an   = w_lit ? ~(N'(1) << r_idx) : '1;
      w_cath = (r_state == S_OFF || w_dark) ? 7'h7F : seg7(w_nib);
      w_dp   = ~(w_lit & r_act_dp[r_idx]);
   end

   // Dropping enable blanks the pins on the very next cycle.
   always_ff @(posedge ClkPort or negedge Reset_n)
      if (!Reset_n) begin
         r_an   <= '1;
         r_cath <= 7'h7F;
         r_dp   <= 1'b1;
         r_fd   <= 1'b0;
      end else begin
         r_an   <= bus.enable ? w_an : '1;
         r_cath <= bus.enable ? w_cath : 7'h7F;
         r_dp   <= ~bus.enable | w_dp;
         r_fd   <= bus.enable & r_wrapped;
      end

   always_ff @(posedge ClkPort or negedge Reset_n)
      if (!Reset_n) begin
         r_sh_val  <= '0;
         r_sh_dp   <= '0;
         r_sh_bl   <= '0;
         r_act_val <= '0;
         r_act_dp  <= '0;
         r_act_bl  <= '0;
         r_pending <= 1'b0;
      end else if (bus.load && (r_state == S_OFF || w_wrap)) begin
         r_sh_val  <= bus.value;
         r_sh_dp   <= bus.dp_in;
         r_sh_bl   <= bus.blank_in;
         r_act_val <= bus.value;
         r_act_dp  <= bus.dp_in;
         r_act_bl  <= bus.blank_in;
         r_pending <= 1'b0;
      end else if (bus.load) begin
         r_sh_val  <= bus.value;
         r_sh_dp   <= bus.dp_in;
         r_sh_bl   <= bus.blank_in;
         r_pending <= 1'b1;
      end else if (w_wrap && r_pending) begin
         r_act_val <= r_sh_val;
         r_act_dp  <= r_sh_dp;
         r_act_bl  <= r_sh_bl;
         r_pending <= 1'b0;
      end

   assign bus.An         = r_an;
   assign bus.Cath       = r_cath;
   assign bus.Dp         = r_dp;
   assign bus.frame_done = r_fd;
   assign bus.pending    = r_pending;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: frame-arithmetic model of the scanner compared every cycle, plus literal pins.
module tb_ssd_scan_ctrl;
   localparam int N = 4, T = 8, G = 2, NT = N * T;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ssd_scan_ctrl_if #(.NUM_DIGITS(N)) bus();
   ssd_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(T), .GUARD(G)) dut (
      .ClkPort(clk),
      .Reset_n(rst_n),
      .bus    (bus)
   );

   typedef struct {
      int         q;
      logic [15:0] v;
      logic [3:0]  dp;
      logic [3:0]  bl;
   } ld_t;

   logic [6:0] segt [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   ld_t         lq[$];
   logic [15:0] b_v;
   logic [3:0]  b_dp, b_bl;
   int          p, pp;
   logic        en_prev, lz_prev;
   bit          chk_on = 1'b1;
   int          n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", nm, got, exp, $time);
   endtask

   // Data shown at position r: the newest load made before r's frame began.
   function automatic void frame_data(input int r, output logic [15:0] v, output logic [3:0] d, output logic [3:0] b);
      v = b_v;
      d = b_dp;
      b = b_bl;
      foreach (lq[i])
         if (lq[i].q < (r / NT) * NT) begin
            v = lq[i].v;
            d = lq[i].dp;
            b = lq[i].bl;
         end
   endfunction

   // p = position of the current cycle within the enabled run; 0 means the DUT is OFF.
   always @(posedge clk) begin
      if (!rst_n) begin
         p = 0; pp = 0; en_prev = 1'b0; lz_prev = 1'b0;
         lq.delete();
         b_v = '0; b_dp = '0; b_bl = '0;
      end else begin
         if (bus.load) begin
            if (p == 0) begin
               lq.delete();
               b_v = bus.value; b_dp = bus.dp_in; b_bl = bus.blank_in;
            end else lq.push_back('{p, bus.value, bus.dp_in, bus.blank_in});
         end
         pp = p;
         en_prev = bus.enable;
         lz_prev = bus.lz_suppress;
         p = bus.enable ? p + 1 : 0;
      end
   end

   always @(negedge clk) begin : cmp
      logic [15:0] v;
      logic [3:0]  dpv, blv, e_an;
      logic [6:0]  e_c;
      logic        e_dp, e_fd, dark, pend;
      int          s, o;
      if (chk_on) begin
         e_an = 4'hF; e_c = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
         if (en_prev && pp > 0) begin
            frame_data(pp, v, dpv, blv);
            s = (pp / T) % N;
            o = pp % T;
            dark = blv[s] | (lz_prev && s > 0 && (v >> (4 * s)) == 16'h0);
            if (!dark) begin
               e_c = segt[v[4*s +: 4]];
               if (o >= G) begin
                  e_an = ~(4'b1 << s);
                  e_dp = ~dpv[s];
               end
            end
            e_fd = (pp % NT) == 0;
         end
         chk("model_An", bus.An, e_an);
         chk("model_Cath", bus.Cath, e_c);
         chk("model_Dp", bus.Dp, e_dp);
         chk("model_frame_done", bus.frame_done, e_fd);
         if (p > 0) begin
            pend = lq.size() > 0 && (lq[lq.size()-1].q / NT) == (p / NT);
            chk("model_pending", bus.pending, pend);
         end
      end
   end

   task automatic wait_p(input int t);
      int k = 0;
      while (p != t && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (p != t) begin
         n_chk++;
         $display("FAIL wait_p: position %0d expected %0d", p, t);
      end
   endtask

   task automatic load_pulse(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      bus.value = v; bus.dp_in = d; bus.blank_in = b; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   initial begin
      bus.enable = 1'b0; bus.load = 1'b0; bus.value = '0;
      bus.dp_in = '0; bus.blank_in = '0; bus.lz_suppress = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_An", bus.An, 4'hF);
      chk("rst_Cath", bus.Cath, 7'h7F);
      chk("rst_Dp", bus.Dp, 1'b1);
      chk("rst_frame_done", bus.frame_done, 1'b0);
      chk("rst_pending", bus.pending, 1'b0);
      // scan order, value 12AF loaded while off
      load_pulse(16'h12AF, 4'h0, 4'h0);
      bus.enable = 1'b1;
      wait_p(3);  chk("scan_d0_An", bus.An, 4'b1110); chk("scan_d0_Cath", bus.Cath, 7'b0111000);
      wait_p(11); chk("scan_d1_An", bus.An, 4'b1101); chk("scan_d1_Cath", bus.Cath, 7'b0001000);
      wait_p(33); chk("scan_fd", bus.frame_done, 1'b1); chk("scan_fd_An", bus.An, 4'hF);
      wait_p(34); chk("scan_fd_low", bus.frame_done, 1'b0);
      // double buffer
      wait_p(40); load_pulse(16'h0000, 4'h0, 4'h0);
      chk("dbuf_pending", bus.pending, 1'b1);
      wait_p(60); chk("dbuf_old_An", bus.An, 4'b0111); chk("dbuf_old_Cath", bus.Cath, 7'b1001111);
      wait_p(67); chk("dbuf_new_Cath", bus.Cath, 7'b0000001); chk("dbuf_pending_clr", bus.pending, 1'b0);
      // load on the wrap cycle
      wait_p(95); load_pulse(16'h3333, 4'h0, 4'h0);
      chk("wrap_pending", bus.pending, 1'b0);
      wait_p(99);  chk("wrap_d0_Cath", bus.Cath, 7'b0000110);
      wait_p(123); chk("wrap_d3_An", bus.An, 4'b0111); chk("wrap_d3_Cath", bus.Cath, 7'b0000110);
      // leading-zero suppression
      bus.enable = 1'b0;
      @(negedge clk);
      chk("off_An", bus.An, 4'hF); chk("off_Cath", bus.Cath, 7'h7F);
      bus.lz_suppress = 1'b1;
      load_pulse(16'h0040, 4'h0, 4'h0);
      bus.enable = 1'b1;
      wait_p(3);  chk("lz_d0_An", bus.An, 4'b1110); chk("lz_d0_Cath", bus.Cath, 7'b0000001);
      wait_p(11); chk("lz_d1_An", bus.An, 4'b1101); chk("lz_d1_Cath", bus.Cath, 7'b1001100);
      wait_p(19); chk("lz_d2_An", bus.An, 4'hF); chk("lz_d2_Cath", bus.Cath, 7'h7F);
      wait_p(27); chk("lz_d3_An", bus.An, 4'hF);
      wait_p(28); load_pulse(16'h0000, 4'h0, 4'h0);
      wait_p(35); chk("lz0_d0_An", bus.An, 4'b1110); chk("lz0_d0_Cath", bus.Cath, 7'b0000001);
      wait_p(43); chk("lz0_d1_An", bus.An, 4'hF); chk("lz0_d1_Cath", bus.Cath, 7'h7F);
      // decimal point, blank and enable
      bus.enable = 1'b0;
      @(negedge clk);
      bus.lz_suppress = 1'b0;
      load_pulse(16'h12AF, 4'b0010, 4'b0001);
      bus.enable = 1'b1;
      wait_p(3);  chk("bl_d0_An", bus.An, 4'hF); chk("bl_d0_Cath", bus.Cath, 7'h7F); chk("bl_d0_Dp", bus.Dp, 1'b1);
      wait_p(9);  chk("dp_guard_Dp", bus.Dp, 1'b1);
      wait_p(11); chk("dp_d1_An", bus.An, 4'b1101); chk("dp_d1_Dp", bus.Dp, 1'b0);
      wait_p(13);
      bus.enable = 1'b0;
      @(negedge clk);
      chk("drop_An", bus.An, 4'hF); chk("drop_Cath", bus.Cath, 7'h7F); chk("drop_Dp", bus.Dp, 1'b1);
      load_pulse(16'h12AF, 4'h0, 4'h0);
      bus.enable = 1'b1;
      wait_p(2); chk("reen_guard_An", bus.An, 4'hF);
      wait_p(3); chk("reen_d0_An", bus.An, 4'b1110); chk("reen_d0_Cath", bus.Cath, 7'b0111000);
      // asynchronous reset mid-drive
      wait_p(12);
      @(posedge clk);
      #2;
      chk_on = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_An", bus.An, 4'hF);
      chk("arst_Cath", bus.Cath, 7'h7F);
      chk("arst_Dp", bus.Dp, 1'b1);
      chk("arst_frame_done", bus.frame_done, 1'b0);
      chk("arst_pending", bus.pending, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
